// File: rtl/ras_ctrl.sv
// ras_ctrl -- return-address stack controller for the fetch stage.
//
// Pushes link addresses (pc+4) on jal/jalr and predicts targets on returns.
// Every accepted fetch also produces a checkpoint of the stack pointer state.
// The backend can hand that checkpoint back to rewind the pointers after a
// mispredict. Entry contents are never rewound.
//
// Optional feature macro: RAS_RESTORE_EN
//   defined   : restore_* inputs are honoured and ckpt_* outputs are live
//   undefined : restore_* inputs are ignored and ckpt_* outputs are tied to 0
//
// Ports:
//   i_clk            clock
//   i_reset          synchronous active-high reset
//   i_fetch_valid    one fetched instruction this cycle
//   i_fetch_pc       PC of that instruction
//   i_fetch_pd       predecode class: 2 return, 5 jal, 6 jalr, others inert
//   i_restore_valid  rewind tos/cnt from a checkpoint (drops same-cycle fetch)
//   i_restore_tos    checkpointed top-of-stack pointer
//   i_restore_cnt    checkpointed occupancy (clamped to DEPTH)
//   o_pred_valid     registered: o_pred_target holds a return prediction
//   o_pred_target    registered predicted return target
//   o_ckpt_tos       registered post-update tos of the previous cycle's fetch
//   o_ckpt_cnt       registered post-update occupancy, same timing
//   o_ckpt_valid     registered: previous cycle had an accepted fetch
module ras_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_fetch_valid,
  input  logic [63:0]      i_fetch_pc,
  input  logic [2:0]       i_fetch_pd,
  input  logic             i_restore_valid,
  input  logic [PTR_W-1:0] i_restore_tos,
  input  logic [PTR_W:0]   i_restore_cnt,
  output logic             o_pred_valid,
  output logic [63:0]      o_pred_target,
  output logic [PTR_W-1:0] o_ckpt_tos,
  output logic [PTR_W:0]   o_ckpt_cnt,
  output logic             o_ckpt_valid
);

  localparam logic [2:0]       LP_PD_RET   = 3'd2;
  localparam logic [2:0]       LP_PD_JAL   = 3'd5;
  localparam logic [2:0]       LP_PD_JALR  = 3'd6;
  localparam logic [PTR_W:0]   LP_CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   LP_CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   LP_CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W-1:0] LP_TOS_RST  = PTR_W'(DEPTH-1);
  localparam logic [PTR_W-1:0] LP_TOS_ONE  = PTR_W'(1);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [PTR_W:0]   r_cnt;
  logic             r_pred_valid;
  logic [63:0]      r_pred_target;

  logic             w_restore;
  logic [PTR_W-1:0] w_rst_tos;
  logic [PTR_W:0]   w_rst_cnt;
  logic             w_accept;
  logic             w_is_call;
  logic             w_is_ret;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_tos_inc;
  logic [PTR_W-1:0] w_tos_next;
  logic [PTR_W:0]   w_cnt_next;

`ifdef RAS_RESTORE_EN
  assign w_restore = i_restore_valid;
  assign w_rst_tos = i_restore_tos;
  // An occupancy beyond DEPTH cannot exist; clamp rather than trust it.
  assign w_rst_cnt = (i_restore_cnt > LP_CNT_FULL) ? LP_CNT_FULL : i_restore_cnt;
`else
  logic w_unused;
  assign w_restore = 1'b0;
  assign w_rst_tos = LP_TOS_RST;
  assign w_rst_cnt = LP_CNT_ZERO;
  assign w_unused  = ^{i_restore_valid, i_restore_tos, i_restore_cnt};
`endif

  // A restore in the same cycle swallows the fetch entirely.
  assign w_accept  = i_fetch_valid & ~w_restore;
  assign w_push    = w_accept & w_is_call;
  // Underflowing returns give no prediction and leave the pointers alone.
  assign w_pop     = w_accept & w_is_ret & (r_cnt != LP_CNT_ZERO);
  assign w_tos_inc = r_tos + LP_TOS_ONE;

  // Predecode class decode.
  always_comb begin
    w_is_call = 1'b0;
    w_is_ret  = 1'b0;
    case (i_fetch_pd)
      LP_PD_JAL, LP_PD_JALR: w_is_call = 1'b1;
      LP_PD_RET:             w_is_ret  = 1'b1;
      default: begin
        w_is_call = 1'b0;
        w_is_ret  = 1'b0;
      end
    endcase
  end

  // Next pointer state: restore, push, pop or hold.
  always_comb begin
    w_tos_next = r_tos;
    w_cnt_next = r_cnt;
    if (w_restore) begin
      w_tos_next = w_rst_tos;
      w_cnt_next = w_rst_cnt;
    end else if (w_push) begin
      w_tos_next = w_tos_inc;
      // Overflow wraps over the oldest entry; occupancy saturates.
      if (r_cnt == LP_CNT_FULL) begin
        w_cnt_next = LP_CNT_FULL;
      end else begin
        w_cnt_next = r_cnt + LP_CNT_ONE;
      end
    end else if (w_pop) begin
      w_tos_next = r_tos - LP_TOS_ONE;
      w_cnt_next = r_cnt - LP_CNT_ONE;
    end else begin
      w_tos_next = r_tos;
      w_cnt_next = r_cnt;
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tos <= LP_TOS_RST;
      r_cnt <= LP_CNT_ZERO;
    end else begin
      r_tos <= w_tos_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Entry array write; contents are deliberately never reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) begin
      r_mem[w_tos_inc] <= i_fetch_pc + 64'd4;
    end
  end

  // Return prediction: the pop reads the entry before this cycle's update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pred_valid  <= 1'b0;
      r_pred_target <= 64'd0;
    end else if (w_pop) begin
      r_pred_valid  <= 1'b1;
      r_pred_target <= r_mem[r_tos];
    end else begin
      r_pred_valid  <= 1'b0;
      r_pred_target <= 64'd0;
    end
  end

  assign o_pred_valid  = r_pred_valid;
  assign o_pred_target = r_pred_target;

`ifdef RAS_RESTORE_EN
  logic             r_ckpt_valid;
  logic [PTR_W-1:0] r_ckpt_tos;
  logic [PTR_W:0]   r_ckpt_cnt;

  // Checkpoint of the post-update pointer state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ckpt_valid <= 1'b0;
      r_ckpt_tos   <= LP_TOS_RST;
      r_ckpt_cnt   <= LP_CNT_ZERO;
    end else begin
      r_ckpt_valid <= w_accept;
      r_ckpt_tos   <= w_tos_next;
      r_ckpt_cnt   <= w_cnt_next;
    end
  end

  assign o_ckpt_valid = r_ckpt_valid;
  assign o_ckpt_tos   = r_ckpt_tos;
  assign o_ckpt_cnt   = r_ckpt_cnt;
`else
  assign o_ckpt_valid = 1'b0;
  assign o_ckpt_tos   = {PTR_W{1'b0}};
  assign o_ckpt_cnt   = LP_CNT_ZERO;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed testbench for ras_ctrl (DEPTH 8). Expected checkpoint values
// collapse to 0 when RAS_RESTORE_EN is not defined.
module tb_ras_ctrl;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
`ifdef RAS_RESTORE_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             fetch_valid;
  logic [63:0]      fetch_pc;
  logic [2:0]       fetch_pd;
  logic             restore_valid;
  logic [PTR_W-1:0] restore_tos;
  logic [PTR_W:0]   restore_cnt;
  logic             pred_valid;
  logic [63:0]      pred_target;
  logic [PTR_W-1:0] ckpt_tos;
  logic [PTR_W:0]   ckpt_cnt;
  logic             ckpt_valid;

  int n_checks = 0;
  int n_errors = 0;

  ras_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_fetch_valid(fetch_valid),
    .i_fetch_pc(fetch_pc),
    .i_fetch_pd(fetch_pd),
    .i_restore_valid(restore_valid),
    .i_restore_tos(restore_tos),
    .i_restore_cnt(restore_cnt),
    .o_pred_valid(pred_valid),
    .o_pred_target(pred_target),
    .o_ckpt_tos(ckpt_tos),
    .o_ckpt_cnt(ckpt_cnt),
    .o_ckpt_valid(ckpt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one fetch for one cycle, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [2:0] pd, input logic [63:0] pc);
    fetch_valid = v;
    fetch_pd    = pd;
    fetch_pc    = pc;
    @(posedge clk);
    #1;
    fetch_valid   = 1'b0;
    fetch_pd      = 3'd0;
    fetch_pc      = 64'd0;
    restore_valid = 1'b0;
  endtask

  task automatic chk_pred(input string tag, input logic v, input logic [63:0] t);
    check_val({tag, ".pred_valid"}, {63'd0, pred_valid}, {63'd0, v});
    if (v) check_val({tag, ".pred_target"}, pred_target, t);
  endtask

  task automatic chk_ck(input string tag, input logic v, input logic [PTR_W-1:0] tos,
                        input logic [PTR_W:0] cnt);
    check_val({tag, ".ckpt_valid"}, {63'd0, ckpt_valid}, {63'd0, v & CK});
    check_val({tag, ".ckpt_tos"}, {61'd0, ckpt_tos}, CK ? {61'd0, tos} : 64'd0);
    check_val({tag, ".ckpt_cnt"}, {60'd0, ckpt_cnt}, CK ? {60'd0, cnt} : 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] inert_pd [4];
    inert_pd[0] = 3'd1; inert_pd[1] = 3'd3; inert_pd[2] = 3'd4; inert_pd[3] = 3'd0;
    reset = 1'b0; fetch_valid = 1'b0; fetch_pc = 64'd0; fetch_pd = 3'd0;
    restore_valid = 1'b0; restore_tos = 3'd0; restore_cnt = 4'd0;

    // Reset values
    do_reset();
    check_val("rst.pred_valid", {63'd0, pred_valid}, 64'd0);
    check_val("rst.pred_target", pred_target, 64'd0);
    chk_ck("rst", 1'b0, 3'd7, 4'd0);

    // Return on an empty stack
    step(1'b1, 3'd2, 64'h500);
    chk_pred("empty_ret", 1'b0, 64'd0);
    chk_ck("empty_ret", 1'b1, 3'd7, 4'd0);

    // jal then return back-to-back
    step(1'b1, 3'd5, 64'h1000);
    chk_ck("jal", 1'b1, 3'd0, 4'd1);
    step(1'b1, 3'd2, 64'h1100);
    chk_pred("jal_ret", 1'b1, 64'h1004);
    chk_ck("jal_ret", 1'b1, 3'd7, 4'd0);

    // 10 calls overflow an 8-deep stack; 9 returns
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, (k % 2 == 1) ? 3'd5 : 3'd6, 64'(k) * 64'h100);
    end
    chk_ck("ovf_push", 1'b1, 3'd1, 4'd8);
    for (int r = 0; r < 8; r++) begin
      step(1'b1, 3'd2, 64'h9000);
      chk_pred($sformatf("ovf_ret%0d", r), 1'b1, 64'hA04 - 64'(r) * 64'h100);
    end
    step(1'b1, 3'd2, 64'h9000);
    chk_pred("ovf_ret8", 1'b0, 64'd0);
    chk_ck("ovf_ret8", 1'b1, 3'd1, 4'd0);

    // Checkpoint restore with a same-cycle return
    do_reset();
    step(1'b1, 3'd5, 64'h1000);
    chk_ck("rs_push1", 1'b1, 3'd0, 4'd1);
    step(1'b1, 3'd6, 64'h2000);
    chk_ck("rs_push2", 1'b1, 3'd1, 4'd2);
    restore_valid = 1'b1; restore_tos = 3'd0; restore_cnt = 4'd1;
    step(1'b1, 3'd2, 64'h3000);
    chk_pred("rs_drop", ~CK, 64'h2004);
    chk_ck("rs_drop", 1'b0, 3'd0, 4'd1);
    step(1'b1, 3'd2, 64'h3004);
    chk_pred("rs_ret", 1'b1, 64'h1004);
    chk_ck("rs_ret", 1'b1, 3'd7, 4'd0);

    // Oversized restore count clamps to DEPTH; entries are not rewound
    restore_valid = 1'b1; restore_tos = 3'd3; restore_cnt = 4'd15;
    step(1'b0, 3'd0, 64'd0);
    step(1'b1, 3'd0, 64'h10);
    chk_ck("clamp", 1'b1, 3'd3, 4'd8);
    step(1'b1, 3'd2, 64'h14);
    chk_pred("clamp_ret", CK, 64'h404);
    chk_ck("clamp_ret", 1'b1, 3'd2, 4'd7);

    // Inert classes between a call and its return
    do_reset();
    step(1'b1, 3'd5, 64'h4000);
    chk_ck("inert_call", 1'b1, 3'd0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, inert_pd[i], 64'h4100 + 64'(i) * 64'h4);
      chk_pred($sformatf("inert%0d", i), 1'b0, 64'd0);
      chk_ck($sformatf("inert%0d", i), 1'b1, 3'd0, 4'd1);
    end
    step(1'b1, 3'd2, 64'h4200);
    chk_pred("inert_ret", 1'b1, 64'h4004);
    chk_ck("inert_ret", 1'b1, 3'd7, 4'd0);
    step(1'b1, 3'd2, 64'h4204);
    chk_pred("inert_ret2", 1'b0, 64'd0);

    // Reset during a return with cnt=3
    do_reset();
    step(1'b1, 3'd5, 64'h10);
    step(1'b1, 3'd6, 64'h20);
    step(1'b1, 3'd5, 64'h30);
    chk_ck("mid_push", 1'b1, 3'd2, 4'd3);
    reset = 1'b1;
    step(1'b1, 3'd2, 64'h40);
    reset = 1'b0;
    check_val("mid_rst.pred_valid", {63'd0, pred_valid}, 64'd0);
    check_val("mid_rst.pred_target", pred_target, 64'd0);
    chk_ck("mid_rst", 1'b0, 3'd7, 4'd0);
    step(1'b1, 3'd2, 64'h44);
    chk_pred("mid_rst_ret", 1'b0, 64'd0);
    chk_ck("mid_rst_ret", 1'b1, 3'd7, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
